// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD coprocessor.
package gcd_pkg;

  typedef enum logic [1:0] {GCD_IDLE, GCD_CALC, GCD_DONE} gcd_state_t;

  localparam int GCD_MODE_EUCLID = 0;
  localparam int GCD_MODE_BINARY = 1;

endpackage

// File: rtl/gcd_step.sv
// One CALC step of the GCD engine: next operands and shift count, or termination value.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = GCD_MODE_EUCLID,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [KW-1:0]    i_k,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [KW-1:0]    o_k,
  output logic             o_term,
  output logic [WIDTH-1:0] o_term_val
);

  logic [WIDTH-1:0] w_base;

  always_comb begin
    o_a    = i_a;
    o_b    = i_b;
    o_k    = i_k;
    o_term = 1'b0;
    w_base = '0;
    if (i_a == '0) begin
      o_term = 1'b1;
      w_base = i_b;
    end else if (i_b == '0) begin
      o_term = 1'b1;
      w_base = i_a;
    end else if (i_a == i_b) begin
      o_term = 1'b1;
      w_base = i_a;
    end else if (MODE == GCD_MODE_BINARY) begin
      if (!i_a[0] && !i_b[0]) begin
        o_a = i_a >> 1;
        o_b = i_b >> 1;
        o_k = i_k + KW'(1);
      end else if (!i_a[0]) begin
        o_a = i_a >> 1;
      end else if (!i_b[0]) begin
        o_b = i_b >> 1;
      end else if (i_a > i_b) begin
        o_a = i_a - i_b;
      end else begin
        o_b = i_b - i_a;
      end
    end else if (i_a > i_b) begin
      o_a = i_a - i_b;
    end else begin
      o_b = i_b - i_a;
    end
  end

  // Common factors of two removed earlier are restored here; gcd <= min(a,b) keeps it in range.
  always_comb begin
    o_term_val = w_base;
    if (MODE == GCD_MODE_BINARY) o_term_val = w_base << i_k;
  end

endmodule

// File: rtl/gcd_unit.sv
// Self-sequencing GCD coprocessor: start/done handshake around a per-cycle gcd_step.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = GCD_MODE_EUCLID
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic [WIDTH-1:0] iter_count
);

  localparam int KW = $clog2(WIDTH) + 1;

  gcd_state_t       r_state, w_next_state;
  logic [WIDTH-1:0] r_a, r_b, r_result, r_iter;
  logic [KW-1:0]    r_k;
  logic             r_zero;

  logic [WIDTH-1:0] w_next_a, w_next_b, w_term_val;
  logic [KW-1:0]    w_next_k;
  logic             w_term;

  gcd_step #(
    .WIDTH(WIDTH),
    .MODE (MODE),
    .KW   (KW)
  ) u_step (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_k       (r_k),
    .o_a       (w_next_a),
    .o_b       (w_next_b),
    .o_k       (w_next_k),
    .o_term    (w_term),
    .o_term_val(w_term_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= GCD_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      GCD_IDLE: if (start) w_next_state = GCD_CALC;
      GCD_CALC: if (w_term) w_next_state = GCD_DONE;
      GCD_DONE: w_next_state = GCD_IDLE;
      default:  w_next_state = GCD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_iter   <= '0;
    end else begin
      case (r_state)
        GCD_IDLE: begin
          if (start) begin
            r_a    <= a_in;
            r_b    <= b_in;
            r_k    <= '0;
            r_iter <= '0;
          end
        end
        GCD_CALC: begin
          if (w_term) begin
            r_result <= w_term_val;
            r_zero   <= (w_term_val == '0);
          end else begin
            r_a <= w_next_a;
            r_b <= w_next_b;
            r_k <= w_next_k;
            if (r_iter != '1) r_iter <= r_iter + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready      = (r_state == GCD_IDLE);
  assign done       = (r_state == GCD_DONE);
  assign result     = r_result;
  assign zero_flag  = r_zero;
  assign iter_count = r_iter;

endmodule

// File: tb/tb_gcd_unit.sv
// Bench for gcd_unit: four instances (Euclid/binary x 8/12 bits) against a number-theoretic reference.
module tb_gcd_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_start[4];
  logic [11:0] s_a[4];
  logic [11:0] s_b[4];
  logic        o_rdy[4];
  logic        o_done[4];
  logic        o_zf[4];
  logic [11:0] o_res[4];
  logic [11:0] o_it[4];

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned wid[4]  = '{8, 8, 12, 12};
  int unsigned mode[4] = '{0, 1, 0, 1};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    localparam int W = (g < 2) ? 8 : 12;
    localparam int M = g % 2;
    logic [W-1:0] res, it;
    logic         rdy, dn, zf;
    gcd_unit #(.WIDTH(W), .MODE(M)) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .start     (s_start[g]),
      .a_in      (s_a[g][W-1:0]),
      .b_in      (s_b[g][W-1:0]),
      .ready     (rdy),
      .done      (dn),
      .result    (res),
      .zero_flag (zf),
      .iter_count(it)
    );
    assign o_res[g]  = 12'(res);
    assign o_it[g]   = 12'(it);
    assign o_rdy[g]  = rdy;
    assign o_done[g] = dn;
    assign o_zf[g]   = zf;
  end

  // Reference: gcd by remainders; subtractive steps = sum of Euclid quotients - 1.
  function automatic void ref_euclid(input int unsigned a, input int unsigned b,
                                     output int unsigned g, output int unsigned it);
    int unsigned x, y, t, s;
    if (a == 0 || b == 0) begin
      g = a + b;
      it = 0;
      return;
    end
    x = a; y = b; s = 0;
    while (y != 0) begin
      s += x / y;
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    it = s - 1;
  endfunction

  function automatic int unsigned ref_binary_iters(input int unsigned a, input int unsigned b);
    int unsigned x, y, n;
    x = a; y = b; n = 0;
    while (!(x == 0 || y == 0 || x == y)) begin
      if (x % 2 == 0 && y % 2 == 0) begin x /= 2; y /= 2; end
      else if (x % 2 == 0) x /= 2;
      else if (y % 2 == 0) y /= 2;
      else if (x > y) x -= y;
      else y -= x;
      n++;
    end
    return n;
  endfunction

  function automatic void ref_model(input int d, input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned it,
                                    output int unsigned lat);
    int unsigned e_it, sat;
    ref_euclid(a, b, g, e_it);
    it  = (mode[d] == 1) ? ref_binary_iters(a, b) : e_it;
    lat = it + 2;
    sat = (1 << wid[d]) - 1;
    if (it > sat) it = sat;
  endfunction

  // Stimulus only: launches at the current negedge, returns on the negedge of the done cycle.
  task automatic run_one(input int d, input int unsigned a, input int unsigned b, input bit hold,
                         output int lat, output bit to);
    s_a[d] = 12'(a); s_b[d] = 12'(b); s_start[d] = 1'b1;
    lat = 0; to = 1'b0;
    forever begin
      @(negedge clk);
      lat++;
      if (!hold) s_start[d] = 1'b0;
      if (o_done[d]) break;
      if (lat > 6000) begin to = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin s_start[d] = 1'b0; s_a[d] = '0; s_b[d] = '0; end
    #23;
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (o_rdy[d] !== 1'b1 || o_done[d] !== 1'b0 || o_res[d] !== '0 || o_zf[d] !== 1'b0 || o_it[d] !== '0) begin
        n_bad++;
        $display("FAIL reset d%0d: got rdy=%b done=%b res=%0d zf=%b it=%0d want 1 0 0 0 0",
                 d, o_rdy[d], o_done[d], o_res[d], o_zf[d], o_it[d]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int ta[8] = '{0, 0, 0, 1, 1, 0, 1, 2};
    int unsigned va[8] = '{12, 0, 0, 12, 255, 255, 0, 35};
    int unsigned vb[8] = '{18, 0, 35, 18, 1, 1, 0, 0};
    int unsigned g, it, elat;
    int lat;
    bit to;
    for (int i = 0; i < 8; i++) begin
      ref_model(ta[i], va[i], vb[i], g, it, elat);
      run_one(ta[i], va[i], vb[i], 1'b0, lat, to);
      n_cmp++;
      if (to) begin n_bad++; $display("FAIL dir%0d timeout: got no done want done", i); end
      n_cmp++;
      if (o_res[ta[i]] !== 12'(g) || o_zf[ta[i]] !== (g == 0)) begin
        n_bad++;
        $display("FAIL dir%0d result: got %0d zf=%b want %0d zf=%b", i, o_res[ta[i]], o_zf[ta[i]], g, g == 0);
      end
      n_cmp++;
      if (o_it[ta[i]] !== 12'(it) || lat != int'(elat)) begin
        n_bad++;
        $display("FAIL dir%0d iter/lat: got %0d/%0d want %0d/%0d", i, o_it[ta[i]], lat, it, elat);
      end
      @(negedge clk);
      n_cmp++;
      if (o_done[ta[i]] !== 1'b0 || o_rdy[ta[i]] !== 1'b1 || o_res[ta[i]] !== 12'(g)) begin
        n_bad++;
        $display("FAIL dir%0d after-done: got done=%b rdy=%b res=%0d want 0 1 %0d",
                 i, o_done[ta[i]], o_rdy[ta[i]], o_res[ta[i]], g);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat = 0;
    bit to = 1'b0;
    s_a[2] = 12'd4095; s_b[2] = 12'd1; s_start[2] = 1'b1;
    forever begin
      @(negedge clk);
      lat++;
      if (o_done[2]) break;
      s_start[2] = (lat % 997 == 3);
      s_a[2] = 12'd10; s_b[2] = 12'd4;
      if (lat % 997 == 3) begin
        n_cmp++;
        if (o_rdy[2] !== 1'b0) begin n_bad++; $display("FAIL busy-ready: got %b want 0", o_rdy[2]); end
      end
      if (lat > 6000) begin to = 1'b1; break; end
    end
    s_start[2] = 1'b0;
    n_cmp++;
    if (to || o_res[2] !== 12'd1 || o_it[2] !== 12'd4094 || lat != 4096) begin
      n_bad++;
      $display("FAIL worst-case: got res=%0d it=%0d lat=%0d want 1 4094 4096", o_res[2], o_it[2], lat);
    end
    @(negedge clk);
    n_cmp++;
    if (o_rdy[2] !== 1'b1) begin n_bad++; $display("FAIL queued-start: got rdy=%b want 1", o_rdy[2]); end
  endtask

  task automatic test_reset_midrun();
    int lat;
    bit to;
    s_a[0] = 12'd200; s_b[0] = 12'd6; s_start[0] = 1'b1;
    @(negedge clk); s_start[0] = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_rdy[0] !== 1'b1 || o_done[0] !== 1'b0 || o_res[0] !== '0 || o_zf[0] !== 1'b0 || o_it[0] !== '0) begin
      n_bad++;
      $display("FAIL midrun-reset: got rdy=%b done=%b res=%0d zf=%b it=%0d want 1 0 0 0 0",
               o_rdy[0], o_done[0], o_res[0], o_zf[0], o_it[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    run_one(0, 9, 6, 1'b0, lat, to);
    n_cmp++;
    if (to || o_res[0] !== 12'd3 || o_it[0] !== 12'd2 || lat != 4) begin
      n_bad++;
      $display("FAIL post-reset run: got res=%0d it=%0d lat=%0d want 3 2 4", o_res[0], o_it[0], lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back(input int d, input int n);
    int unsigned a, b, g, it, elat, mask;
    int lat;
    bit to;
    mask = (1 << wid[d]) - 1;
    for (int i = 0; i < n; i++) begin
      a = $urandom & mask;
      b = $urandom & mask;
      case ($urandom_range(0, 15))
        0: a = 0;
        1: b = 0;
        2: b = a;
        default: ;
      endcase
      ref_model(d, a, b, g, it, elat);
      run_one(d, a, b, 1'b1, lat, to);
      if (i == n - 1) s_start[d] = 1'b0;
      n_cmp++;
      if (to || o_res[d] !== 12'(g) || o_zf[d] !== (g == 0) || o_it[d] !== 12'(it) || lat != int'(elat)) begin
        n_bad++;
        $display("FAIL rand d%0d a=%0d b=%0d: got res=%0d zf=%b it=%0d lat=%0d want %0d %b %0d %0d",
                 d, a, b, o_res[d], o_zf[d], o_it[d], lat, g, g == 0, it, elat);
      end
      @(negedge clk);
      n_cmp++;
      if (o_rdy[d] !== 1'b1 || o_done[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b-idle d%0d: got rdy=%b done=%b want 1 0", d, o_rdy[d], o_done[d]);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_midrun();
    fork
      test_back_to_back(0, 400);
      test_back_to_back(1, 400);
      test_back_to_back(2, 150);
      test_back_to_back(3, 150);
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
